// File: rtl/stream_pwd_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwd_pkg
// Brief    : Shared symbol constants and FSM state type for stream_pwd_checker.
// Revision : 1.0 - initial release
// ============================================================================
package pwd_pkg;

    localparam int                SYM_W     = 6;
    localparam logic [SYM_W-1:0]  SYM_ENTER = 6'h3F;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        LOCKED  = 1'b1
    } pwd_state_t;

endpackage
`default_nettype wire

// File: rtl/stream_pwd_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_pwd_checker_if
// Brief    : Symbol stream, password programming port and status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_pwd_checker_if;
    import pwd_pkg::*;

    logic             sym_valid;
    logic [SYM_W-1:0] sym;
    logic             prog_we;
    logic [3:0]       prog_idx;
    logic [SYM_W-1:0] prog_sym;
    logic             unlock;
    logic             fail;
    logic             locked;
    logic [3:0]       fail_cnt;

    modport master (
        output sym_valid, sym, prog_we, prog_idx, prog_sym,
        input  unlock, fail, locked, fail_cnt
    );

    modport slave (
        input  sym_valid, sym, prog_we, prog_idx, prog_sym,
        output unlock, fail, locked, fail_cnt
    );

endinterface
`default_nettype wire

// File: rtl/stream_pwd_checker_lock_timer.sv
`default_nettype none
// ============================================================================
// Module   : pwd_lock_timer
// Brief    : Down-counter holding the lockout for LOCK_CYCLES clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pwd_lock_timer #(
    parameter int LOCK_CYCLES = 1000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic start,
    output logic      busy,
    output logic      done
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Loaded on start; done flags the last cycle so the owner leaves lockout
    // exactly LOCK_CYCLES cycles after the load edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= CNT_W'(LOCK_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign busy = (r_cnt != '0);
    assign done = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/stream_pwd_checker.sv
`default_nettype none
// ============================================================================
// Module   : stream_pwd_checker
// Brief    : Compares a delimited symbol stream against a programmable password.
//            Define PWD_LOCKOUT_EN to enable the timed lockout after MAX_FAIL
//            consecutive failures.
// Revision : 1.0 - initial release
// ============================================================================
module stream_pwd_checker
    import pwd_pkg::*;
#(
    parameter int PWD_LEN     = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  wire logic           clk,
    input  wire logic           reset,
    stream_pwd_checker_if.slave bus
);

    localparam int POS_W = 5;

    logic [SYM_W-1:0] r_pwd [PWD_LEN];
    logic [POS_W-1:0] r_pos;
    logic             r_err;
    logic [3:0]       r_fail_cnt;
    logic             r_unlock;
    logic             r_fail;

    logic             w_collect;
    logic             w_lock_expire;
    logic             w_prog_ok;
    logic             w_take;
    logic             w_enter;
    logic             w_char;
    logic             w_full;
    logic             w_match;
    logic [3:0]       w_cnt_inc;
    logic [SYM_W-1:0] w_exp;

`ifdef PWD_LOCKOUT_EN
    pwd_state_t r_state;
    logic       r_locked;
    logic       w_lock_start;
    logic       w_busy;
    logic       w_done;

    assign w_collect     = (r_state == COLLECT);
    assign w_lock_expire = (r_state == LOCKED) && w_done;
    assign w_lock_start  = w_enter && !w_match && (w_cnt_inc == 4'(MAX_FAIL)) && !w_busy;

    pwd_lock_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_timer (
        .clk   (clk),
        .reset (reset),
        .start (w_lock_start),
        .busy  (w_busy),
        .done  (w_done)
    );

    assign bus.locked = r_locked;
`else
    assign w_collect     = 1'b1;
    assign w_lock_expire = 1'b0;
    assign bus.locked    = 1'b0;
`endif

    // Writes to positions beyond the password are ignored but still drop the symbol.
    assign w_prog_ok = bus.prog_we && ({1'b0, bus.prog_idx} < POS_W'(PWD_LEN));
    assign w_take    = bus.sym_valid && !bus.prog_we && w_collect;
    assign w_enter   = w_take && (bus.sym == SYM_ENTER);
    assign w_char    = w_take && (bus.sym != SYM_ENTER);
    assign w_full    = (r_pos == POS_W'(PWD_LEN));
    assign w_match   = w_full && !r_err;
    assign w_cnt_inc = (r_fail_cnt == 4'hF) ? 4'hF : r_fail_cnt + 4'd1;

    always_comb begin
        w_exp = '0;
        for (int i = 0; i < PWD_LEN; i++) begin
            if (r_pos == POS_W'(i)) begin
                w_exp = r_pwd[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos      <= '0;
            r_err      <= 1'b0;
            r_fail_cnt <= '0;
            r_unlock   <= 1'b0;
            r_fail     <= 1'b0;
            for (int i = 0; i < PWD_LEN; i++) begin
                r_pwd[i] <= '0;
            end
`ifdef PWD_LOCKOUT_EN
            r_state    <= COLLECT;
            r_locked   <= 1'b0;
`endif
        end else begin
            r_unlock <= 1'b0;
            r_fail   <= 1'b0;

            for (int i = 0; i < PWD_LEN; i++) begin
                if (bus.prog_we && (bus.prog_idx == 4'(i))) begin
                    r_pwd[i] <= bus.prog_sym;
                end
            end

            if (w_prog_ok) begin
                r_pos <= '0;
                r_err <= 1'b0;
            end else if (w_enter) begin
                r_pos <= '0;
                r_err <= 1'b0;
                if (w_match) begin
                    r_unlock   <= 1'b1;
                    r_fail_cnt <= '0;
                end else begin
                    r_fail     <= 1'b1;
                    r_fail_cnt <= w_cnt_inc;
                end
            end else if (w_char) begin
                if (w_full) begin
                    r_err <= 1'b1;
                end else begin
                    if (bus.sym != w_exp) begin
                        r_err <= 1'b1;
                    end
                    r_pos <= r_pos + POS_W'(1);
                end
            end

            if (w_lock_expire) begin
                r_fail_cnt <= '0;
            end

`ifdef PWD_LOCKOUT_EN
            if (w_lock_start) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
            end else if (w_lock_expire) begin
                r_state  <= COLLECT;
                r_locked <= 1'b0;
            end
`endif
        end
    end

    assign bus.unlock   = r_unlock;
    assign bus.fail     = r_fail;
    assign bus.fail_cnt = r_fail_cnt;

endmodule
`default_nettype wire

// File: doc/stream_pwd_checker.md
STREAM_PWD_CHECKER -- requirements
Module: stream_pwd_checker

Interface
REQ-001 Parameter PWD_LEN, default 4: number of symbols in the stored password, range 1..16.
REQ-002 Parameter MAX_FAIL, default 3: consecutive failed entries that trigger lockout, range 1..15.
REQ-003 Parameter LOCK_CYCLES, default 1000: lockout duration in clk cycles, minimum 1.
REQ-004 clk  in  1  clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 sym_valid  in  1  sym SHALL be sampled only when high.
REQ-007 sym  in  6  input symbol from the registered 6-bit symbol stage; 6'h3F is ENTER (delimiter).
REQ-008 prog_we  in  1  password-write strobe.
REQ-009 prog_idx  in  4  password position to write.
REQ-010 prog_sym  in  6  symbol to store.
REQ-011 unlock  out  1  one-cycle pulse: correct entry.
REQ-012 fail  out  1  one-cycle pulse: wrong entry.
REQ-013 locked  out  1  level: lockout active.
REQ-014 fail_cnt  out  4  current count of consecutive failures.

Function
REQ-015 The FSM SHALL have exactly two states, COLLECT and LOCKED.
REQ-016 In COLLECT, a valid non-ENTER symbol at position pos < PWD_LEN SHALL set err if sym != pwd[pos]; pos SHALL then increment.
REQ-017 A valid non-ENTER symbol at pos == PWD_LEN SHALL set err; pos SHALL saturate at PWD_LEN.
REQ-018 On a valid ENTER with pos == PWD_LEN and err == 0: unlock SHALL pulse on the following cycle and fail_cnt SHALL clear.
REQ-019 On any other valid ENTER, including an empty entry (pos == 0): fail SHALL pulse on the following cycle and fail_cnt SHALL increment.
REQ-020 Every ENTER SHALL clear pos and err.
REQ-021 When an increment makes fail_cnt == MAX_FAIL, the FSM SHALL enter LOCKED in the same cycle that fail pulses; locked SHALL assert in that cycle.
REQ-022 In LOCKED, sym_valid SHALL be ignored; the lock timer SHALL count LOCK_CYCLES cycles.
REQ-023 On timer expiry, the FSM SHALL return to COLLECT, fail_cnt SHALL clear, and locked SHALL deassert.
REQ-024 prog_we SHALL write prog_sym into pwd[prog_idx] and clear pos and err, in any state.
REQ-025 A write with prog_idx >= PWD_LEN SHALL be ignored and SHALL NOT clear pos or err.
REQ-026 If prog_we and sym_valid are both high in a cycle, the write SHALL win and the symbol SHALL be dropped.
REQ-027 Outputs unlock and fail SHALL be registered and SHALL never be high in the same cycle.

Reset
REQ-028 Reset SHALL set state = COLLECT, pos = 0, err = 0, fail_cnt = 0, unlock = 0, fail = 0, locked = 0, lock timer = 0, and every pwd entry = 6'h00.
REQ-029 Reset asserted during LOCKED or mid-entry SHALL abort it immediately, with no unlock or fail pulse.

Configuration
REQ-030 Macro PWD_LOCKOUT_EN defined: LOCKED state, lock timer and fail_cnt saturation behave per REQ-021..023.
REQ-031 Macro PWD_LOCKOUT_EN undefined: no LOCKED state and no timer; locked SHALL be tied to 0; fail_cnt SHALL saturate at 15 and clear on unlock.

Structure
REQ-032 Package pwd_pkg SHALL hold SYM_W = 6, SYM_ENTER = 6'h3F, and the state enum typedef pwd_state_t {COLLECT, LOCKED}.
REQ-033 The lock timer SHALL be a sub-module pwd_lock_timer (start, busy, done; parameter LOCK_CYCLES).

Verification
REQ-034 Program pwd = 1,2,3,4; send 1,2,3,4,ENTER -> unlock high exactly one cycle after ENTER, fail_cnt = 0.
REQ-035 Send 1,2,9,4,ENTER -> fail pulse, fail_cnt = 1; then 1,2,3,4,ENTER -> unlock, fail_cnt = 0.
REQ-036 Send three wrong entries with LOCK_CYCLES = 10 -> locked rises with the third fail; a correct entry while locked gives no pulse; locked falls after 10 cycles, fail_cnt = 0.
REQ-037 Send 1,2,3,4,5,ENTER or ENTER alone -> fail each time; send 1,2 then prog_we (idx 0) together with sym_valid -> entry aborted, symbol dropped.
REQ-038 Assert reset mid-entry and mid-lockout -> all outputs 0 the next cycle, no pulses; pwd reads back as all 6'h00.
